// File: rtl/vga_draw_arbiter_if.sv
// Pixel-write bus between the per-object draw FSMs and the arbiter, plus the arbiter's VGA-side outputs.
// The master side (draw FSMs) drives the request bus; the slave side (arbiter) drives grant and the VGA port.
interface vga_draw_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       last;
    logic [NUM_REQ-1:0]       write_en_in;
    logic [NUM_REQ*X_W-1:0]   x_in;
    logic [NUM_REQ*Y_W-1:0]   y_in;
    logic [NUM_REQ*COL_W-1:0] colour_in;
    logic [NUM_REQ-1:0]       grant;
    logic [X_W-1:0]           vga_x;
    logic [Y_W-1:0]           vga_y;
    logic [COL_W-1:0]         vga_colour;
    logic                     vga_plot;
    logic                     busy;
    logic                     timeout;

    modport master (
        output req, last, write_en_in, x_in, y_in, colour_in,
        input  grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
    );

    modport slave (
        input  req, last, write_en_in, x_in, y_in, colour_in,
        output grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the single VGA pixel write port between NUM_REQ draw FSMs.
// state | meaning
// IDLE  | no owner; pick next requester after rr_ptr, at least one cycle between bursts
// BURST | requester rr_ptr owns the port until last, request drop, or MAX_BURST cycles
module vga_draw_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COL_W     = 3,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_draw_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic               timeout_q, timeout_nxt;
    logic               plot_q;
    logic [X_W-1:0]     vga_x_q;
    logic [Y_W-1:0]     vga_y_q;
    logic [COL_W-1:0]   vga_colour_q;

    logic               found;
    logic [PTR_W-1:0]   cand, win;
    logic               sel_req, sel_last, sel_we;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COL_W-1:0]   sel_colour;
    logic               pix_ok;

    // While in BURST rr_ptr is the granted index, so it drives the data mux directly.
    always_comb begin
        sel_req    = 1'b0;
        sel_last   = 1'b0;
        sel_we     = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == rr_ptr) begin
                sel_req    = bus.req[i];
                sel_last   = bus.last[i];
                sel_we     = bus.write_en_in[i];
                sel_x      = bus.x_in[i*X_W +: X_W];
                sel_y      = bus.y_in[i*Y_W +: Y_W];
                sel_colour = bus.colour_in[i*COL_W +: COL_W];
            end
        end
    end

    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        cand  = rr_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k >= NUM_REQ) ? PTR_W'(int'(rr_ptr) + k - NUM_REQ)
                                                 : PTR_W'(int'(rr_ptr) + k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt      = BURST;
                    grant_nxt      = '0;
                    grant_nxt[win] = 1'b1;
                    rr_ptr_nxt     = win;
                    burst_cnt_nxt  = CNT_W'(1);
                end
            end
            BURST: begin
                // Normal release wins over the count limit, so no timeout when both coincide.
                if (sel_last || !sel_req) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    burst_cnt_nxt = '0;
                end else if (burst_cnt == CNT_W'(MAX_BURST)) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    burst_cnt_nxt = '0;
                    timeout_nxt   = 1'b1;
                end else begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign pix_ok = (state == BURST) && sel_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            plot_q <= pix_ok;
            if (pix_ok) begin
                vga_x_q      <= sel_x;
                vga_y_q      <= sel_y;
                vga_colour_q <= sel_colour;
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = (state == BURST);
    assign bus.timeout    = timeout_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_vga_draw_arbiter;
    localparam int N    = 4;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;
    localparam int MAXB = 16;

    typedef struct {
        logic [N-1:0]  grant;
        logic          plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] col;
        logic          to;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    vga_draw_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COL_W(CW)) bus ();

    vga_draw_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COL_W(CW), .MAX_BURST(MAXB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    int   glog[$];
    int   to_cnt = 0;
    logic [N-1:0] prev_g = '0;

    // reference model: who owns the port, whose turn is next, how long the burst has run
    int   m_own = -1;
    int   m_ptr = N - 1;
    int   m_cnt = 0;
    exp_t m_e;
    logic [N-1:0] rq = '0;
    bit   t1_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_ptr = N - 1;
        m_cnt = 0;
        m_e.grant = '0; m_e.plot = 1'b0; m_e.x = '0; m_e.y = '0; m_e.col = '0; m_e.to = 1'b0;
    endtask

    task automatic model_step();
        exp_t n;
        bit   hit;
        n = m_e;
        n.to = 1'b0;
        n.plot = 1'b0;
        if (m_own >= 0 && bus.write_en_in[m_own]) begin
            n.plot = 1'b1;
            n.x    = bus.x_in[m_own*XW +: XW];
            n.y    = bus.y_in[m_own*YW +: YW];
            n.col  = bus.colour_in[m_own*CW +: CW];
        end
        if (m_own < 0) begin
            hit = 0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!hit && bus.req[i]) begin
                    hit = 1; m_own = i; m_ptr = i; m_cnt = 1;
                end
            end
        end else if (bus.last[m_own] || !bus.req[m_own]) begin
            m_own = -1;
        end else if (m_cnt == MAXB) begin
            m_own = -1;
            n.to = 1'b1;
        end else begin
            m_cnt++;
        end
        n.grant = (m_own < 0) ? '0 : N'(1 << m_own);
        m_e = n;
        sbq.push_back(n);
    endtask

    // modes: 0 random, 1 single 3-pixel burst, 2 all request 2-cycle bursts, 3 req2 never last,
    // 4 req1 with foreign pixels, 5 req2 last on the count limit, 6 quiet
    task automatic drive_cycle(input int mode);
        logic [N-1:0] r, l, w;
        @(negedge clk);
        r = '0; l = '0; w = N'($urandom);
        case (mode)
            0: begin
                for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
                r = rq;
                for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 5) == 0);
            end
            1: begin
                r = t1_done ? 4'b0000 : 4'b0001;
                w = 4'b1111;
                if (m_own == 0 && m_cnt == 3) begin l = 4'b0001; t1_done = 1; end
            end
            2: begin
                r = 4'b1111;
                for (int i = 0; i < N; i++) l[i] = (m_own == i && m_cnt == 2);
            end
            3: r = 4'b0100;
            4: begin
                r = 4'b0010;
                w = {2'b11, m_cnt[0], 1'b1};
                l = 4'b1101;
            end
            5: begin
                r = 4'b0100;
                l[2] = (m_own == 2 && m_cnt == MAXB);
            end
            default: ;
        endcase
        bus.req = r;
        bus.last = l;
        bus.write_en_in = w;
        bus.x_in = $urandom;
        bus.y_in = $urandom;
        bus.colour_in = N*CW'($urandom);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        bus.req = '0; bus.last = '0; bus.write_en_in = '0;
        #1;
        chk("reset_grant", int'(bus.grant), 0);
        chk("reset_plot", int'(bus.vga_plot), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_timeout", int'(bus.timeout), 0);
        chk("reset_x", int'(bus.vga_x), 0);
        sbq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // monitor: one expected record per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                prev_g = '0;
            end else if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("grant", int'(bus.grant), int'(e.grant));
                chk("busy", int'(bus.busy), int'(e.grant != '0));
                chk("timeout", int'(bus.timeout), int'(e.to));
                chk("vga_plot", int'(bus.vga_plot), int'(e.plot));
                chk("vga_x", int'(bus.vga_x), int'(e.x));
                chk("vga_y", int'(bus.vga_y), int'(e.y));
                chk("vga_colour", int'(bus.vga_colour), int'(e.col));
                if (bus.timeout) to_cnt++;
                if (bus.grant != '0 && prev_g == '0) glog.push_back(int'(bus.grant));
                prev_g = bus.grant;
            end
        end
    end

    initial begin
        int base;
        int order[5];
        reset_n = 1'b0;
        bus.req = '0; bus.last = '0; bus.write_en_in = '0;
        bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
        model_reset();
        do_reset();

        repeat (8) drive_cycle(1);
        repeat (2) drive_cycle(6);
        repeat (10) drive_cycle(4);

        do_reset();
        glog.delete();
        repeat (16) drive_cycle(2);
        repeat (3) drive_cycle(6);
        order = '{1, 2, 4, 8, 1};
        if (glog.size() < 5) begin
            chk("grant_order_count", glog.size(), 5);
        end else begin
            for (int i = 0; i < 5; i++) chk("grant_order", glog[i], order[i]);
        end

        base = to_cnt;
        repeat (35) drive_cycle(3);
        repeat (3) drive_cycle(6);
        chk("forced_release_count", to_cnt - base, 2);

        base = to_cnt;
        repeat (20) drive_cycle(5);
        repeat (3) drive_cycle(6);
        chk("last_at_limit_timeout", to_cnt - base, 0);

        for (int c = 0; c < 3000; c++) begin
            drive_cycle(0);
            if (c % 500 == 250) do_reset();
        end
        repeat (3) drive_cycle(6);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
